// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, IR, accumulator, register file, ALU and z/c flags for the
// 8-bit accumulator CPU. Driven by the controller's per-cycle strobes and
// returns the current opcode and flags to it.
//
// Strobe semantics: every strobe is a single-cycle command sampled on the
// rising clk edge. There is no valid/ready handshake. A strobe that is high
// at an edge takes effect at that edge. All readers of fld/op see the IR
// value from before the edge.
module cpu_datapath #(
   parameter int DW   = 8,   // accumulator / register / ALU width (>= 4)
   parameter int PW   = 8,   // program counter width (>= 4)
   parameter int NREG = 16   // register-file depth (2..16)
)(
   input  logic          clk,
   input  logic          CLB,
   input  logic          LoadIR,
   input  logic          IncPC,
   input  logic          SelPC,
   input  logic          LoadPC,
   input  logic          LoadReg,
   input  logic          LoadAcc,
   input  logic [1:0]    SelAcc,
   input  logic [3:0]    SelALU,
   output logic [PW-1:0] imem_addr,
   input  logic [7:0]    imem_data,
   output logic [3:0]    op,
   output logic          z,
   output logic          c,
   output logic [DW-1:0] acc_out,
   output logic [PW-1:0] pc_out
);

   localparam int RI = (NREG > 1) ? $clog2(NREG) : 1;

   logic [PW-1:0] pc_q;
   logic [7:0]    ir_q;
   logic [DW-1:0] acc_q;
   logic          z_q;
   logic          c_q;
   logic [DW-1:0] rf_q [NREG];

   logic [3:0]    fld;
   logic [RI-1:0] ridx;
   logic [DW-1:0] rdat;
   logic [DW-1:0] alu_r;
   logic          alu_cout;
   logic [DW-1:0] acc_src;
   logic          acc_load;
   logic          jump_cond;
   logic [PW-1:0] jump_tgt;

   assign fld  = ir_q[3:0];
   assign ridx = fld[RI-1:0];
   assign rdat = rf_q[ridx];

   // ALU: combinational function of Acc and R[fld], selected by SelALU
   always_comb begin
      alu_r    = acc_q;
      alu_cout = 1'b0;
      case (SelALU)
         4'b0001: {alu_cout, alu_r} = {1'b0, acc_q} + {1'b0, rdat};
         4'b0010: begin
            alu_r    = acc_q - rdat;
            alu_cout = (acc_q < rdat);
         end
         4'b0011: alu_r = ~(acc_q | rdat);
         4'b1011: begin
            alu_r    = {acc_q[DW-2:0], 1'b0};
            alu_cout = acc_q[DW-1];
         end
         4'b1100: begin
            alu_r    = {1'b0, acc_q[DW-1:1]};
            alu_cout = acc_q[0];
         end
         default: ;
      endcase
   end

   // Accumulator source mux; SelAcc=01 is reserved and freezes Acc and flags
   always_comb begin
      acc_load = LoadAcc && (SelAcc != 2'b01);
      case (SelAcc)
         2'b10:   acc_src = rdat;
         2'b11:   acc_src = DW'(fld);
         default: acc_src = alu_r;
      endcase
   end

   // Jump condition from current opcode and pre-edge flags; target from fld or R[fld]
   always_comb begin
      case (ir_q[7:4])
         4'b0110, 4'b0111: jump_cond = z_q;
         4'b1000, 4'b1010: jump_cond = c_q;
         default:          jump_cond = 1'b1;
      endcase
      jump_tgt = SelPC ? PW'(rdat) : PW'(fld);
   end

   // PC, IR, accumulator and flag registers
   always_ff @(posedge clk or posedge CLB) begin
      if (CLB) begin
         pc_q  <= '0;
         ir_q  <= '0;
         acc_q <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
      end else begin
         if (LoadPC && jump_cond) pc_q <= jump_tgt;
         else if (IncPC)          pc_q <= pc_q + 1'b1;
         if (LoadIR) ir_q <= imem_data;
         if (acc_load) begin
            acc_q <= acc_src;
            z_q   <= (acc_src == '0);
            if (SelAcc == 2'b00) c_q <= alu_cout;
         end
      end
   end

   // Register file write; stores the pre-edge accumulator
   always_ff @(posedge clk or posedge CLB) begin
      if (CLB) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (LoadReg) begin
         rf_q[ridx] <= acc_q;
      end
   end

   assign imem_addr = pc_q;
   assign pc_out    = pc_q;
   assign op        = ir_q[7:4];
   assign z         = z_q;
   assign c         = c_q;
   assign acc_out   = acc_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed vector table, an asynchronous mid-run reset
// sequence and a randomized phase compared against an arithmetic model.
module tb_cpu_datapath;

   localparam int DW   = 8;
   localparam int PW   = 8;
   localparam int NREG = 16;

   logic          clk;
   logic          CLB;
   logic          LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
   logic [1:0]    SelAcc;
   logic [3:0]    SelALU;
   logic [PW-1:0] imem_addr;
   logic [7:0]    imem_data;
   logic [3:0]    op;
   logic          z, c;
   logic [DW-1:0] acc_out;
   logic [PW-1:0] pc_out;

   cpu_datapath #(.DW(DW), .PW(PW), .NREG(NREG)) dut (
      .clk(clk), .CLB(CLB),
      .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
      .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .op(op), .z(z), .c(c), .acc_out(acc_out), .pc_out(pc_out)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       lir;
      logic [7:0] imem;
      logic       inc, spc, lpc, lreg, lacc;
      logic [1:0] sacc;
      logic [3:0] alu;
      logic [7:0] e_acc, e_pc;
      logic       e_z, e_c;
      logic [3:0] e_op;
   } vec_t;

   vec_t tbl[$];

   // scoreboard: {acc, pc, z, c, op}
   logic [21:0] exp_q[$];

   // behavioural reference state
   int m_pc, m_ir, m_acc, m_z, m_c;
   int m_r[NREG];

   function automatic vec_t v(input logic lir, input logic [7:0] imem,
                              input logic inc, input logic spc, input logic lpc,
                              input logic lreg, input logic lacc,
                              input logic [1:0] sacc, input logic [3:0] alu,
                              input logic [7:0] e_acc, input logic [7:0] e_pc,
                              input logic e_z, input logic e_c, input logic [3:0] e_op);
      vec_t t;
      t.lir = lir; t.imem = imem; t.inc = inc; t.spc = spc; t.lpc = lpc;
      t.lreg = lreg; t.lacc = lacc; t.sacc = sacc; t.alu = alu;
      t.e_acc = e_acc; t.e_pc = e_pc; t.e_z = e_z; t.e_c = e_c; t.e_op = e_op;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // driver tasks
   task automatic idle();
      LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; LoadReg = 0; LoadAcc = 0;
      SelAcc = 2'b00; SelALU = 4'h0; imem_data = 8'h00;
   endtask

   task automatic drive(input vec_t t);
      LoadIR = t.lir; imem_data = t.imem; IncPC = t.inc; SelPC = t.spc;
      LoadPC = t.lpc; LoadReg = t.lreg; LoadAcc = t.lacc;
      SelAcc = t.sacc; SelALU = t.alu;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
      for (int i = 0; i < NREG; i++) m_r[i] = 0;
   endtask

   // Reference model: one instruction-step of the datapath from the rules,
   // using integer arithmetic on the pre-edge state.
   task automatic model_step();
      int f, ri, rv, r, co, opc, s, tgt, old_acc, cond;
      f = m_ir % 16; ri = f % NREG; rv = m_r[ri]; opc = m_ir / 16;
      old_acc = m_acc;
      r = m_acc; co = 0;
      case (int'(SelALU))
         1:  begin s = m_acc + rv; r = s % 256; co = (s > 255) ? 1 : 0; end
         2:  begin s = m_acc - rv; r = (s + 256) % 256; co = (s < 0) ? 1 : 0; end
         3:  begin r = 255 - (m_acc | rv); co = 0; end
         11: begin r = (m_acc * 2) % 256; co = m_acc / 128; end
         12: begin r = m_acc / 2; co = m_acc % 2; end
         default: ;
      endcase
      if (opc == 6 || opc == 7)       cond = m_z;
      else if (opc == 8 || opc == 10) cond = m_c;
      else                            cond = 1;
      tgt = SelPC ? rv : f;
      if (LoadPC && cond != 0) m_pc = tgt;
      else if (IncPC)          m_pc = (m_pc + 1) % 256;
      if (LoadAcc) begin
         case (int'(SelAcc))
            0: begin m_acc = r; m_c = co; m_z = (r == 0) ? 1 : 0; end
            2: begin m_acc = rv; m_z = (rv == 0) ? 1 : 0; end
            3: begin m_acc = f; m_z = (f == 0) ? 1 : 0; end
            default: ;
         endcase
      end
      if (LoadReg) m_r[ri] = old_acc;
      if (LoadIR)  m_ir = int'(imem_data);
      exp_q.push_back({8'(m_acc), 8'(m_pc), 1'(m_z), 1'(m_c), 4'(m_ir / 16)});
   endtask

   logic [21:0] e;

   initial begin
      idle();
      CLB = 1'b1;
      #12;
      chk("rst_acc", acc_out, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_op", op, 0);
      chk("rst_z", z, 0);
      chk("rst_c", c, 0);
      @(negedge clk);
      CLB = 1'b0;

      // lir imem inc spc lpc lreg lacc sacc alu | acc pc z c op
      tbl.push_back(v(1,'hDF,0,0,0,0,0,0,0,     'h00,'h00,0,0,'hD)); // LDIM prep
      tbl.push_back(v(0,'h00,0,0,0,0,1,3,0,     'h0F,'h00,0,0,'hD)); // Acc=0F
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h1E,'h00,0,0,'hD));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h3C,'h00,0,0,'hD));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h78,'h00,0,0,'hD));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'hF0,'h00,0,0,'hD));
      tbl.push_back(v(1,'h53,0,0,0,0,0,0,0,     'hF0,'h00,0,0,'h5));
      tbl.push_back(v(1,'hD1,0,0,0,1,0,0,0,     'hF0,'h00,0,0,'hD)); // R3=F0, old IR used
      tbl.push_back(v(1,'h13,0,0,0,0,1,3,0,     'h01,'h00,0,0,'h1));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'h1,   'hF1,'h00,0,0,'h1)); // 01+F0
      tbl.push_back(v(1,'h52,0,0,0,0,0,0,0,     'hF1,'h00,0,0,'h5));
      tbl.push_back(v(1,'hDF,0,0,0,1,0,0,0,     'hF1,'h00,0,0,'hD)); // R2=F1
      tbl.push_back(v(1,'h12,0,0,0,0,1,3,0,     'h0F,'h00,0,0,'h1)); // Acc=0F
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'h1,   'h00,'h00,1,1,'h1)); // ADD overflow
      tbl.push_back(v(1,'hD5,0,0,0,0,0,0,0,     'h00,'h00,1,1,'hD));
      tbl.push_back(v(1,'h51,0,0,0,0,1,3,0,     'h05,'h00,0,1,'h5)); // LDIM keeps c
      tbl.push_back(v(1,'hD3,0,0,0,1,0,0,0,     'h05,'h00,0,1,'hD)); // R1=05
      tbl.push_back(v(1,'h21,0,0,0,0,1,3,0,     'h03,'h00,0,1,'h2));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'h2,   'hFE,'h00,0,1,'h2)); // SUB borrow
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hC,   'h7F,'h00,0,0,'h2)); // SHR
      tbl.push_back(v(0,'h00,0,0,0,0,1,1,'h1,   'h7F,'h00,0,0,'h2)); // reserved SelAcc
      tbl.push_back(v(1,'hD0,0,0,0,0,0,0,0,     'h7F,'h00,0,0,'hD));
      tbl.push_back(v(1,'h79,0,0,0,0,1,3,0,     'h00,'h00,1,0,'h7)); // z=1, IR=JZIM 9
      tbl.push_back(v(0,'h00,0,0,1,0,0,0,0,     'h00,'h09,1,0,'h7)); // jump taken
      tbl.push_back(v(0,'h00,0,0,0,0,1,3,0,     'h09,'h09,0,0,'h7)); // z=0
      tbl.push_back(v(0,'h00,1,0,1,0,0,0,0,     'h09,'h0A,0,0,'h7)); // not taken, inc
      tbl.push_back(v(0,'h00,0,0,1,0,0,0,0,     'h09,'h0A,0,0,'h7)); // not taken, hold
      tbl.push_back(v(1,'hD4,0,0,0,0,0,0,0,     'h09,'h0A,0,0,'hD));
      tbl.push_back(v(1,'h53,0,0,0,0,1,3,0,     'h04,'h0A,0,0,'h5));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h08,'h0A,0,0,'h5));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h10,'h0A,0,0,'h5));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h20,'h0A,0,0,'h5));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h40,'h0A,0,0,'h5));
      tbl.push_back(v(1,'h83,0,0,0,1,0,0,0,     'h40,'h0A,0,0,'h8)); // R3=40, JCRS 3
      tbl.push_back(v(0,'h00,0,1,1,0,0,0,0,     'h40,'h0A,0,0,'h8)); // c=0: ignored
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h80,'h0A,0,0,'h8));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h00,'h0A,1,1,'h8)); // c=1
      tbl.push_back(v(0,'h00,0,1,1,0,0,0,0,     'h00,'h40,1,1,'h8)); // PC=R3
      tbl.push_back(v(1,'hDA,0,0,0,0,0,0,0,     'h00,'h40,1,1,'hD));
      tbl.push_back(v(1,'h57,0,0,0,0,1,3,0,     'h0A,'h40,0,1,'h5));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h14,'h40,0,0,'h5));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h28,'h40,0,0,'h5));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h50,'h40,0,0,'h5));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'hA0,'h40,0,0,'h5));
      tbl.push_back(v(1,'hD5,0,0,0,1,0,0,0,     'hA0,'h40,0,0,'hD)); // R7=A0
      tbl.push_back(v(1,'h17,0,0,0,0,1,3,0,     'h05,'h40,0,0,'h1));
      tbl.push_back(v(1,'h56,0,0,0,0,1,0,'h1,   'hA5,'h40,0,0,'h5)); // Acc=A5
      tbl.push_back(v(1,'h46,0,0,0,1,0,0,0,     'hA5,'h40,0,0,'h4)); // MOVA R6
      tbl.push_back(v(0,'h00,0,0,0,0,1,3,0,     'h06,'h40,0,0,'h4));
      tbl.push_back(v(0,'h00,0,0,0,0,1,2,0,     'hA5,'h40,0,0,'h4)); // MOVR R6
      tbl.push_back(v(1,'h30,0,0,0,0,0,0,0,     'hA5,'h40,0,0,'h3));
      tbl.push_back(v(0,'h00,0,0,0,0,1,3,0,     'h00,'h40,1,0,'h3));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'h3,   'hFF,'h40,0,0,'h3)); // NOR
      tbl.push_back(v(1,'h90,0,0,0,1,0,0,0,     'hFF,'h40,0,0,'h9)); // R0=FF
      tbl.push_back(v(0,'h00,0,1,1,0,0,0,0,     'hFF,'h FF,0,0,'h9)); // PC=FF
      tbl.push_back(v(1,'h97,1,0,0,0,0,0,0,     'hFF,'h00,0,0,'h9)); // wrap
      tbl.push_back(v(0,'h00,1,0,1,0,0,0,0,     'hFF,'h07,0,0,'h9)); // jump beats inc
      tbl.push_back(v(1,'h95,0,0,0,0,0,0,0,     'hFF,'h07,0,0,'h9));
      tbl.push_back(v(1,'hDF,0,0,1,0,0,0,0,     'hFF,'h05,0,0,'hD)); // PC=05
      tbl.push_back(v(0,'h00,0,0,0,0,1,3,0,     'h0F,'h05,0,0,'hD));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h1E,'h05,0,0,'hD));
      tbl.push_back(v(0,'h00,0,0,0,0,1,0,'hB,   'h3C,'h05,0,0,'hD)); // Acc=3C

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         tick();
         chk($sformatf("vec%0d_acc", i), acc_out, tbl[i].e_acc);
         chk($sformatf("vec%0d_pc", i), pc_out, tbl[i].e_pc);
         chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_pc);
         chk($sformatf("vec%0d_z", i), z, tbl[i].e_z);
         chk($sformatf("vec%0d_c", i), c, tbl[i].e_c);
         chk($sformatf("vec%0d_op", i), op, tbl[i].e_op);
      end
      idle();

      // asynchronous reset in the middle of a clock phase
      #3;
      CLB = 1'b1;
      #1;
      chk("arst_acc", acc_out, 0);
      chk("arst_pc", pc_out, 0);
      chk("arst_addr", imem_addr, 0);
      chk("arst_op", op, 0);
      chk("arst_z", z, 0);
      chk("arst_c", c, 0);
      LoadIR = 1; imem_data = 8'hFF; IncPC = 1; LoadAcc = 1; SelAcc = 2'b11;
      tick();
      chk("arst_hold_pc", pc_out, 0);
      chk("arst_hold_acc", acc_out, 0);
      chk("arst_hold_op", op, 0);
      idle();
      @(negedge clk);
      CLB = 1'b0;
      model_reset();

      // randomized phase against the reference model
      for (int n = 0; n < 600; n++) begin
         LoadIR    = ($urandom_range(0, 1) == 1);
         imem_data = 8'($urandom_range(0, 255));
         IncPC     = ($urandom_range(0, 1) == 1);
         SelPC     = ($urandom_range(0, 1) == 1);
         LoadPC    = ($urandom_range(0, 3) == 0);
         LoadReg   = ($urandom_range(0, 3) == 0);
         LoadAcc   = ($urandom_range(0, 2) != 0);
         SelAcc    = 2'($urandom_range(0, 3));
         SelALU    = 4'($urandom_range(0, 15));
         model_step();
         tick();
         if (exp_q.size() == 0) begin
            chk("rnd_queue_empty", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("rnd%0d_acc", n), acc_out, e[21:14]);
            chk($sformatf("rnd%0d_pc", n), pc_out, e[13:6]);
            chk($sformatf("rnd%0d_addr", n), imem_addr, e[13:6]);
            chk($sformatf("rnd%0d_z", n), z, e[5]);
            chk($sformatf("rnd%0d_c", n), c, e[4]);
            chk($sformatf("rnd%0d_op", n), op, e[3:0]);
         end
      end
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath stage directly downstream of the CPU controller FSM: consumes its LoadIR/IncPC/SelPC/LoadPC/LoadReg/LoadAcc/SelAcc/SelALU strobes.
- Returns the current opcode and the z/c flags to the controller.
- Holds PC, IR, accumulator, register file, ALU and flags, and drives the instruction-memory address.
- Instruction word is 8 bits: op = IR[7:4], fld = IR[3:0]. fld is either a register index or a 4-bit immediate, zero-extended.

Parameters:
- DW, 8, accumulator, register and ALU data width (>=4)
- PW, 8, program counter / instruction address width (>=4)
- NREG, 16, register-file depth; fld indexes it modulo NREG (uses fld[$clog2(NREG)-1:0])

Ports:
- clk  in  1  rising-edge clock
- CLB  in  1  asynchronous active-high reset
- LoadIR  in  1  latch imem_data into IR
- IncPC  in  1  PC <= PC+1
- SelPC  in  1  jump target source: 0 = zero-extended fld, 1 = R[fld] (low PW bits)
- LoadPC  in  1  conditional jump load
- LoadReg  in  1  R[fld] <= Acc
- LoadAcc  in  1  Acc <= selected source
- SelAcc  in  2  Acc source: 00 = ALU, 10 = R[fld], 11 = zero-extended fld, 01 = reserved
- SelALU  in  4  ALU function (opcode encoding)
- imem_addr  out  PW  equals PC
- imem_data  in  8  asynchronous instruction-memory read data
- op  out  4  IR[7:4]
- z  out  1  zero flag
- c  out  1  carry flag
- acc_out  out  DW  accumulator, observation only
- pc_out  out  PW  PC, observation only

Behaviour:
- Reset (CLB=1, asynchronous, any time including mid-instruction): PC=0, IR=0, Acc=0, z=0, c=0, all NREG registers=0. Outputs follow immediately: op=0, imem_addr=0.
- All state updates occur on rising clk only while CLB=0. No combinational path from strobes to the state outputs.
- IR: if LoadIR, IR <= imem_data. Otherwise IR holds.
- PC priority, highest first:
  - LoadPC with condition true: PC <= target.
  - IncPC: PC <= PC+1, wrapping from 2^PW-1 to 0.
  - Otherwise PC holds.
- Jump condition is evaluated from the current op and the pre-edge flags:
  - JZRS(0110), JZIM(0111): require z=1.
  - JCRS(1000), JCIM(1010): require c=1.
  - Any other op with LoadPC: treated as unconditional.
  - Condition false: LoadPC is ignored and IncPC, if also asserted, still applies.
- Jump target: SelPC=0 gives {0, fld}. SelPC=1 gives R[fld] truncated or zero-extended to PW.
- ALU is combinational on (Acc, R[fld]). Result r is DW bits; cout is 1 bit:
  - 0001 ADD: {cout,r} = Acc + R[fld].
  - 0010 SUB: r = Acc - R[fld]; cout = borrow (1 when Acc < R[fld], unsigned).
  - 0011 NOR: r = ~(Acc | R[fld]); cout = 0.
  - 1011 SHL: r = Acc << 1; cout = Acc[DW-1].
  - 1100 SHR: r = Acc >> 1 (logical); cout = Acc[0].
  - Any other code: r = Acc; cout = 0.
- Acc load (LoadAcc=1):
  - SelAcc=00: Acc <= r; c <= cout.
  - SelAcc=10: Acc <= R[fld]; c holds.
  - SelAcc=11: Acc <= zero-extended fld; c holds.
  - SelAcc=01: Acc, z and c all hold.
  - For 00/10/11, z <= (new Acc == 0).
- Flags change only on LoadAcc. Jumps, register writes and IR loads leave z/c unchanged.
- Register write: if LoadReg, R[fld] <= Acc (pre-edge value).
- Same-edge combinations:
  - LoadReg and LoadAcc together: R gets the old Acc; Acc gets the new value.
  - LoadIR together with any fld/op user: users see the old IR, and IR updates at the edge.
- Latency: every strobe takes effect at the next rising edge. op/z/c are valid one cycle after the load that produced them.

Test Plan:
- Reset mid-run: pulse CLB asynchronously while PC=0x05, Acc=0x3C -> PC, Acc, IR, z and c read 0 immediately, before any clk edge; imem_addr=0.
- LDIM then ADD overflow:
  - imem=0xDF; LoadIR, then LoadAcc with SelAcc=11 -> Acc=0x0F, z=0.
  - R[2]=0xF1; SelALU=0001, SelAcc=00, fld=2 -> Acc=0x00, c=1, z=1.
- SUB borrow and SHR: Acc=0x03, R[1]=0x05, SUB -> Acc=0xFE, c=1, z=0. Then SHR -> Acc=0x7F, c=0.
- Conditional jumps:
  - IR=0x79 (JZIM, fld=9), z=1, LoadPC, SelPC=0 -> PC=0x09.
  - Same with z=0 and IncPC also asserted -> PC=old+1.
  - JCRS fld=3, R[3]=0x40, c=1 -> PC=0x40.
- MOVA/MOVR: Acc=0xA5, IR=0x56, LoadReg -> R[6]=0xA5, flags unchanged. Then IR=0x46, MOVR load -> Acc=0xA5, z=0, c unchanged.
- PC wrap and priority: PC=0xFF, IncPC -> PC=0x00. LoadPC (true condition) and IncPC together -> target wins.
